// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// router_pkg : word format shared by the router and the merger
// Rev 1.0
// ============================================================================
package router_pkg;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_NUM_CH     = 4;

    function automatic int calc_addr_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int calc_data_w(input int data_width, input int num_ch);
        return data_width - calc_addr_w(num_ch);
    endfunction

    localparam int DEF_ADDR_W = calc_addr_w(DEF_NUM_CH);
    localparam int DEF_DATA_W = calc_data_w(DEF_DATA_WIDTH, DEF_NUM_CH);

    // Address sits in the MSBs so the router can slice it straight off the top.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] payload;
    } word_t;

endpackage
`default_nettype wire

// File: rtl/channel_fifo.sv
`default_nettype none
// ============================================================================
// channel_fifo : per-channel synchronous FIFO with explicit occupancy count
// Rev 1.0
// ============================================================================
module channel_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic                              do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        // Full blocks a write even when a pop lands on the same edge.
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/merger.sv
`default_nettype none
// ============================================================================
// merger : NUM_CH valid/ready channels -> one {addr, payload} stream (RR arb)
// Rev 1.0
// ============================================================================
module merger
    import router_pkg::*;
#(
    parameter int  DATA_WIDTH = 10,
    parameter int  NUM_CH     = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int ADDR_W     = calc_addr_w(NUM_CH),
    localparam int DATA_W     = calc_data_w(DATA_WIDTH, NUM_CH)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_CH-1:0]              valid_i,
    output logic [NUM_CH-1:0]              ready_o,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  data_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [DATA_WIDTH-1:0]          data_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] payload;
    } out_word_t;

    logic [NUM_CH-1:0]             fifo_full;
    logic [NUM_CH-1:0]             fifo_empty;
    logic [NUM_CH-1:0]             fifo_push;
    logic [NUM_CH-1:0]             fifo_pop;
    logic [NUM_CH-1:0][DATA_W-1:0] fifo_rdata;

    logic              valid_q, valid_d;
    out_word_t         data_q, data_d;
    logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic              load_en;
    logic              grant_valid;
    logic [ADDR_W-1:0] grant_idx;
    logic [ADDR_W-1:0] scan_idx;

    // Ready is a pure decode of registered occupancy, gated low during reset.
    assign ready_o   = ~fifo_full & {NUM_CH{~rst_i}};
    assign fifo_push = valid_i & ready_o;

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            channel_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (fifo_push[ch]),
                .pop_i   (fifo_pop[ch]),
                .wdata_i (data_i[ch]),
                .rdata_o (fifo_rdata[ch]),
                .full_o  (fifo_full[ch]),
                .empty_o (fifo_empty[ch])
            );
        end
    endgenerate

    // Round-robin search from rr_ptr; NUM_CH is a power of two so the add wraps.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = rr_ptr_q + ADDR_W'(i);
            if (!grant_valid && !fifo_empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        load_en  = !valid_q || ready_i;
        fifo_pop = '0;
        valid_d  = valid_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            if (grant_valid) begin
                fifo_pop[grant_idx] = 1'b1;
                data_d.addr         = grant_idx;
                data_d.payload      = fifo_rdata[grant_idx];
                valid_d             = 1'b1;
                rr_ptr_d            = grant_idx + ADDR_W'(1);
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_merger.sv
`default_nettype none
// ============================================================================
// tb_merger : directed vector table plus an asynchronous mid-stream reset
// Rev 1.0
// ============================================================================
module tb_merger;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [3:0]       valid_i = '0;
    logic [3:0]       ready_o;
    logic [3:0][7:0]  data_i = '0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [9:0]       data_o;

    int n_tests = 0;
    int n_fail  = 0;

    merger #(
        .DATA_WIDTH (10),
        .NUM_CH     (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            rst;
        logic [3:0]      vin;
        logic [3:0][7:0] din;
        logic            rdy;
        logic            exp_valid;
        logic [9:0]      exp_data;
        logic [3:0]      exp_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] vin,
                       input logic [7:0] d3, input logic [7:0] d2,
                       input logic [7:0] d1, input logic [7:0] d0,
                       input logic rdy, input logic ev,
                       input logic [9:0] ed, input logic [3:0] er);
        vec_t v;
        v.rst = rst; v.vin = vin; v.din = {d3, d2, d1, d0}; v.rdy = rdy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_ready = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Each row: inputs applied at negedge, outputs checked 1ns after the next posedge.
        add(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 10'h000, 4'h0);
        // Single word on ch2
        add(0, 4'b0100, 8'h00, 8'hA1, 8'h00, 8'h00, 1, 0, 10'h000, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h2A1, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 10'h2A1, 4'hF);
        // All four channels in one cycle
        add(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 10'h000, 4'h0);
        add(0, 4'b1111, 8'h44, 8'h33, 8'h22, 8'h11, 1, 0, 10'h000, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h011, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h122, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h233, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h344, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 10'h344, 4'hF);
        // Output stalled on 0A1, ch1 fills, fifth word held off, then drain
        add(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 10'h000, 4'h0);
        add(0, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hA1, 0, 0, 10'h000, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 10'h0A1, 4'hF);
        add(0, 4'b0010, 8'h00, 8'h00, 8'h51, 8'h00, 0, 1, 10'h0A1, 4'hF);
        add(0, 4'b0010, 8'h00, 8'h00, 8'h52, 8'h00, 0, 1, 10'h0A1, 4'hF);
        add(0, 4'b0010, 8'h00, 8'h00, 8'h53, 8'h00, 0, 1, 10'h0A1, 4'hF);
        add(0, 4'b0010, 8'h00, 8'h00, 8'h54, 8'h00, 0, 1, 10'h0A1, 4'hD);
        add(0, 4'b0010, 8'h00, 8'h00, 8'h55, 8'h00, 0, 1, 10'h0A1, 4'hD);
        add(0, 4'b0010, 8'h00, 8'h00, 8'h55, 8'h00, 1, 1, 10'h151, 4'hF);
        add(0, 4'b0010, 8'h00, 8'h00, 8'h55, 8'h00, 1, 1, 10'h152, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h153, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h154, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h155, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 10'h155, 4'hF);
        // Fairness between ch0 and ch3
        add(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 10'h000, 4'h0);
        add(0, 4'b1001, 8'h31, 8'h00, 8'h00, 8'h01, 0, 0, 10'h000, 4'hF);
        add(0, 4'b1001, 8'h32, 8'h00, 8'h00, 8'h02, 0, 1, 10'h001, 4'hF);
        add(0, 4'b1001, 8'h33, 8'h00, 8'h00, 8'h03, 0, 1, 10'h001, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h331, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h002, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h332, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h003, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 10'h333, 4'hF);
        add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 10'h333, 4'hF);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            rst_i   = vecs[i].rst;
            valid_i = vecs[i].vin;
            data_i  = vecs[i].din;
            ready_i = vecs[i].rdy;
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d data_o", i),  32'(data_o),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(vecs[i].exp_ready));
        end

        // Asynchronous reset between edges with three words in flight
        @(negedge clk_i);
        ready_i = 1'b0;
        valid_i = 4'b0111;
        data_i  = {8'h00, 8'h63, 8'h62, 8'h61};
        @(posedge clk_i);
        #1;
        check("queue valid_o", 32'(valid_o), 32'(1'b0));
        @(negedge clk_i);
        valid_i = 4'b0000;
        data_i  = '0;
        @(posedge clk_i);
        #1;
        check("queue head data_o", 32'(data_o), 32'(10'h061));
        check("queue head valid_o", 32'(valid_o), 32'(1'b1));
        #2;
        rst_i = 1'b1;
        #1;
        check("async rst valid_o", 32'(valid_o), 32'(1'b0));
        check("async rst ready_o", 32'(ready_o), 32'(4'h0));
        check("async rst data_o", 32'(data_o), 32'(10'h000));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        #1;
        check("post rst ready_o", 32'(ready_o), 32'(4'hF));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("post rst stale%0d valid_o", k), 32'(valid_o), 32'(1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
